// File: rtl/vx_cache_core_req_dispatch_if.sv
// Core-request batch port and per-bank dispatch port of the bank request dispatcher.
// Batch handshake: accepted on a clock edge where core_req_ready is high and any core_req_valid bit is set.
// Bank handshake: bank b retires its request on an edge where per_bank_valid[b] and per_bank_ready[b] are both high.
interface vx_cache_core_req_dispatch_if #(
  parameter int NUM_BANKS       = 4,
  parameter int NUM_REQUESTS    = 4,
  parameter int WORD_ADDR_WIDTH = 30
);
  localparam int RIW = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  logic [NUM_REQUESTS-1:0]                 core_req_valid;
  logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] core_req_addr;
  logic                                    split_en;
  logic                                    core_req_ready;
  logic [NUM_BANKS-1:0]                    per_bank_valid;
  logic [NUM_BANKS*RIW-1:0]                per_bank_req_idx;
  logic [NUM_BANKS*WORD_ADDR_WIDTH-1:0]    per_bank_addr;
  logic [NUM_BANKS-1:0]                    per_bank_ready;
  logic                                    batch_done;

  modport master (
    output core_req_valid, core_req_addr, split_en, per_bank_ready,
    input  core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr, batch_done
  );

  modport slave (
    input  core_req_valid, core_req_addr, split_en, per_bank_ready,
    output core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr, batch_done
  );
endinterface

// File: rtl/vx_cache_core_req_dispatch.sv
// Registered core-request dispatcher: captures a batch, maps requests to banks and drains
// same-bank conflicts over several cycles with a per-bank round-robin pointer.
module vx_cache_core_req_dispatch #(
  parameter int BANK_LINE_SIZE  = 16,
  parameter int WORD_SIZE       = 4,
  parameter int NUM_BANKS       = 4,
  parameter int NUM_REQUESTS    = 4,
  parameter int WORD_ADDR_WIDTH = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  vx_cache_core_req_dispatch_if.slave   bus,
  output logic [31:0]                   conflict_cnt,
  output logic                          dbg_state_o
);
  localparam int NR        = NUM_REQUESTS;
  localparam int NB        = NUM_BANKS;
  localparam int AW        = WORD_ADDR_WIDTH;
  localparam int WOFF      = $clog2(BANK_LINE_SIZE / WORD_SIZE);
  localparam int BSW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int RIW       = (NR > 1) ? $clog2(NR) : 1;
  localparam bit SPLIT_OK  = (NB % NR) == 0;
  localparam int SPLIT_DIV = (NB >= NR) ? NB / NR : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [NR-1:0]           pend_q, pend_d;
  logic [NR-1:0][AW-1:0]   addr_q, addr_d;
  logic                    split_q, split_d;
  logic [NB-1:0][RIW-1:0]  rr_q, rr_d;
  logic [31:0]             cnt_q, cnt_d;

  logic [NR-1:0][BSW-1:0]  req_bank;
  logic [NB-1:0][NR-1:0]   gnt_vec;
  logic [NB-1:0][RIW-1:0]  gnt_idx;
  logic [NB-1:0][AW-1:0]   gnt_addr;
  logic [NB-1:0]           gnt_any;
  logic [NB-1:0]           losers;
  logic [NR-1:0]           retire;
  logic [NR-1:0]           remain;
  logic                    busy;
  logic                    accept;

  // Split mode gives request i its own group of NB/NR banks.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      if (NB == 1) begin
        req_bank[i] = '0;
      end else if (split_q && SPLIT_OK) begin
        req_bank[i] = BSW'(i * SPLIT_DIV) + (addr_q[i][WOFF +: BSW] & BSW'(SPLIT_DIV - 1));
      end else begin
        req_bank[i] = addr_q[i][WOFF +: BSW];
      end
    end
  end

  always_comb begin
    int k;
    k        = 0;
    gnt_vec  = '0;
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_any  = '0;
    losers   = '0;
    for (int b = 0; b < NB; b++) begin
      for (int off = 0; off < NR; off++) begin
        k = (int'(rr_q[b]) + off) % NR;
        if (!gnt_any[b] && pend_q[k] && (req_bank[k] == BSW'(b))) begin
          gnt_any[b]    = 1'b1;
          gnt_vec[b][k] = 1'b1;
          gnt_idx[b]    = RIW'(k);
          gnt_addr[b]   = addr_q[k];
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (pend_q[r] && (req_bank[r] == BSW'(b)) && !gnt_vec[b][r]) losers[b] = 1'b1;
      end
    end
  end

  always_comb begin
    retire = '0;
    for (int b = 0; b < NB; b++) begin
      if (gnt_any[b] && bus.per_bank_ready[b]) retire = retire | gnt_vec[b];
    end
  end

  assign busy   = (state_q == BUSY);
  assign remain = pend_q & ~retire;
  assign accept = bus.core_req_ready && (|bus.core_req_valid);

  // Ready overlaps the final retire so a new batch can be taken without a bubble.
  always_comb begin
    bus.core_req_ready   = !reset && (!busy || (remain == '0));
    bus.batch_done       = !reset && busy && (remain == '0);
    bus.per_bank_valid   = reset ? '0 : gnt_any;
    bus.per_bank_req_idx = gnt_idx;
    bus.per_bank_addr    = gnt_addr;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    split_d = split_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (busy) begin
      pend_d = remain;
      // A cycle counts only when a bank actually retired while others at that bank waited.
      if (|(losers & bus.per_bank_ready)) cnt_d = cnt_q + 32'd1;
      for (int b = 0; b < NB; b++) begin
        if (gnt_any[b] && bus.per_bank_ready[b]) begin
          rr_d[b] = (gnt_idx[b] == RIW'(NR - 1)) ? '0 : gnt_idx[b] + RIW'(1);
        end
      end
      if (remain == '0) state_d = IDLE;
    end
    if (accept) begin
      pend_d  = bus.core_req_valid;
      addr_d  = bus.core_req_addr;
      split_d = bus.split_en;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      split_q <= 1'b0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      split_q <= split_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      assert (!bus.split_en || SPLIT_OK)
        else $error("split_en set while NUM_BANKS is not a multiple of NUM_REQUESTS");
    end
  end

  assign conflict_cnt = cnt_q;
  assign dbg_state_o  = busy;
endmodule

// File: tb/tb_vx_cache_core_req_dispatch.sv
// Randomized bench for the core request dispatcher with a per-bank service-order reference model.
module tb_vx_cache_core_req_dispatch;
  localparam int NB   = 4;
  localparam int NR   = 4;
  localparam int AW   = 30;
  localparam int BLS  = 16;
  localparam int WS   = 4;
  localparam int WOFF = 2;
  localparam int RIW  = 2;
  localparam int W    = RIW + AW;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] conflict_cnt;
  logic        dbg_state;

  always #5 clk = ~clk;

  vx_cache_core_req_dispatch_if #(.NUM_BANKS(NB), .NUM_REQUESTS(NR), .WORD_ADDR_WIDTH(AW)) bus ();

  vx_cache_core_req_dispatch #(
    .BANK_LINE_SIZE(BLS), .WORD_SIZE(WS), .NUM_BANKS(NB), .NUM_REQUESTS(NR), .WORD_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(conflict_cnt), .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [NB][$];
  int rem_q[$];
  int model_rr [NB];
  int model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bank_of(input int i, input logic [AW-1:0] a, input logic s);
    int bb;
    bb = int'(a >> WOFF) % NB;
    if (s && (NB % NR == 0)) return i * (NB / NR) + bb % (NB / NR);
    return bb;
  endfunction

  // Each bank serves its requests in cyclic index order starting at its pointer.
  task automatic push_batch(input logic [NR-1:0] m, input logic [NR*AW-1:0] a, input logic s);
    int k, last, n;
    logic [AW-1:0] ak;
    n = 0;
    for (int b = 0; b < NB; b++) begin
      last = -1;
      for (int off = 0; off < NR; off++) begin
        k = (model_rr[b] + off) % NR;
        ak = a[k*AW +: AW];
        if (m[k] && bank_of(k, ak, s) == b) begin
          exp_q[b].push_back({RIW'(k), ak});
          last = k;
          n++;
        end
      end
      if (last >= 0) model_rr[b] = (last + 1) % NR;
    end
    rem_q.push_back(n);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int retires;
    bit conf, exp_done, exp_ready;
    if (reset) begin
      check("rst_valid", 64'(bus.per_bank_valid), 64'd0);
      check("rst_ready", 64'(bus.core_req_ready), 64'd0);
      check("rst_done", 64'(bus.batch_done), 64'd0);
      for (int b = 0; b < NB; b++) begin
        exp_q[b].delete();
        model_rr[b] = 0;
      end
      rem_q.delete();
      model_cnt = 0;
    end else begin
      check("conflict_cnt", 64'(conflict_cnt), 64'(model_cnt));
      check("busy_state", 64'(dbg_state), 64'(rem_q.size() > 0));
      retires = 0;
      conf = 1'b0;
      for (int b = 0; b < NB; b++) begin
        check($sformatf("valid_b%0d", b), 64'(bus.per_bank_valid[b]), 64'(exp_q[b].size() > 0));
        if (bus.per_bank_valid[b] && exp_q[b].size() > 0) begin
          check($sformatf("idx_addr_b%0d", b),
                64'({bus.per_bank_req_idx[b*RIW +: RIW], bus.per_bank_addr[b*AW +: AW]}),
                64'(exp_q[b][0]));
          if (bus.per_bank_ready[b]) begin
            void'(exp_q[b].pop_front());
            retires++;
            if (exp_q[b].size() > 0) conf = 1'b1;
          end
        end
      end
      exp_done  = (rem_q.size() > 0) && (retires == rem_q[0]);
      exp_ready = (rem_q.size() == 0) || exp_done;
      check("batch_done", 64'(bus.batch_done), 64'(exp_done));
      check("core_req_ready", 64'(bus.core_req_ready), 64'(exp_ready));
      if (exp_done) void'(rem_q.pop_front());
      else if (rem_q.size() > 0) rem_q[0] = rem_q[0] - retires;
      if (conf) model_cnt++;
      if (exp_ready && (|bus.core_req_valid))
        push_batch(bus.core_req_valid, bus.core_req_addr, bus.split_en);
    end
  end

  function automatic logic [AW-1:0] mk_addr(input int bank);
    logic [AW-1:0] t;
    t = AW'($urandom);
    t[WOFF +: 2] = 2'(bank);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] m, input int b0, input int b1, input int b2, input int b3,
                       input logic s);
    bus.core_req_valid = m;
    bus.core_req_addr  = {mk_addr(b3), mk_addr(b2), mk_addr(b1), mk_addr(b0)};
    bus.split_en       = s;
  endtask

  task automatic idle_inputs();
    bus.core_req_valid = '0;
    bus.split_en       = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.core_req_valid = '0;
    bus.core_req_addr  = '0;
    bus.split_en       = 1'b0;
    bus.per_bank_ready = '1;
    repeat (3) step();
    reset = 1'b0;

    // No valid bits in IDLE: nothing captured
    repeat (3) begin
      bus.per_bank_ready = 4'($urandom);
      step();
    end
    bus.per_bank_ready = '1;

    // Disjoint banks, a new batch every cycle
    repeat (6) begin
      drive(4'b1111, 0, 1, 2, 3, 1'b0);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // All four to bank 2, always ready
    drive(4'b1111, 2, 2, 2, 2, 1'b0);
    step();
    idle_inputs();
    repeat (6) step();

    // Same, with bank 2 stalled for three cycles first
    drive(4'b1111, 2, 2, 2, 2, 1'b0);
    step();
    idle_inputs();
    bus.per_bank_ready = 4'b1011;
    repeat (3) step();
    bus.per_bank_ready = '1;
    repeat (6) step();

    // Split mode: bank bits 1 everywhere, still spread across banks
    drive(4'b1111, 1, 1, 1, 1, 1'b1);
    step();
    idle_inputs();
    repeat (3) step();

    // Reset in the second busy cycle of a conflicting batch
    drive(4'b1111, 2, 2, 2, 2, 1'b0);
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bus.core_req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus.core_req_addr  = {mk_addr($urandom_range(0, 3)), mk_addr($urandom_range(0, 3)),
                            mk_addr($urandom_range(0, 1)), mk_addr($urandom_range(0, 1))};
      bus.split_en       = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < NB; b++) bus.per_bank_ready[b] = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    bus.per_bank_ready = '1;
    repeat (10) step();

    @(negedge clk);
    #1;
    check("drain_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()
                             + rem_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
